video_sync_monitor: RTL and testbench

- Downstream stage between the colour-bar pattern generator and the video DAC/connector pins.
- Measures incoming hsync/vsync timing against expected line/frame totals and declares lock after consecutive good frames.
- Registers and forwards the syncs, and adds a composite sync.
- Blanks RGB to black whenever the timing is not locked, so a monitor never sees pattern data on malformed timing.

---
 rtl/video_sync_monitor.sv | 150 +++++++++++++++
 tb/tb_video_sync_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/video_sync_monitor.sv
// Sync timing monitor: measures line/frame lengths, locks after consecutive good frames, forwards syncs + composite sync.
// Latency: one clk from a pix_en-qualified input sample to the registered outputs.
// Backpressure: none; pix_en low freezes every register, RGB is blanked to black whenever timing is not locked.
module video_sync_monitor #(
   parameter int H_TOTAL     = 381,
   parameter int V_TOTAL     = 262,
   parameter int LOCK_FRAMES = 4,
   parameter bit SYNC_HIGH   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_en,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic [2:0] rgb_in,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       csync_out,
   output logic [2:0] rgb_out,
   output logic       locked,
   output logic [9:0] line_len,
   output logic [9:0] frame_lines
);

   localparam logic [10:0] H_LEN     = 11'(H_TOTAL);
   localparam logic [9:0]  V_LINES   = 10'(V_TOTAL);
   localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);
   localparam logic [9:0]  CNT_MAX   = 10'h3FF;
   localparam logic        SYNC_IDLE = ~SYNC_HIGH;

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t      state, state_nxt;
   logic [3:0]  good, good_nxt;
   logic [9:0]  hcnt, vcnt;
   logic        hs_prev, vs_prev;
   logic        line_err;

   logic        hs_n, vs_n;
   logic        hedge, vedge;
   logic [10:0] line_meas;
   logic        line_bad;
   logic        hcnt_sat, vcnt_sat;
   logic        frame_good;

   // Syncs are handled active-high internally; edges are judged against the previous pixel sample.
   assign hs_n       = SYNC_HIGH ? hsync_in : ~hsync_in;
   assign vs_n       = SYNC_HIGH ? vsync_in : ~vsync_in;
   assign hedge      = hs_n & ~hs_prev;
   assign vedge      = vs_n & ~vs_prev;
   assign line_meas  = {1'b0, hcnt} + 11'd1;
   assign line_bad   = hedge && (line_meas != H_LEN);
   assign hcnt_sat   = (hcnt == CNT_MAX);
   assign vcnt_sat   = (vcnt == CNT_MAX);
   // The hedge coinciding with a vedge belongs to the new frame, so the closing frame is judged on line_err as stored.
   assign frame_good = (vcnt == V_LINES) && !line_err;
   assign locked     = (state == LOCKED);

   // Lock state register and good-frame counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= SEARCH;
         good  <= 4'd0;
      end else begin
         state <= state_nxt;
         good  <= good_nxt;
      end
   end

   // Next-state: arm on a vedge, count consecutive good frames, drop on any timing violation or lost hsync.
   always_comb begin
      state_nxt = state;
      good_nxt  = good;
      if (pix_en) begin
         if (hcnt_sat) begin
            state_nxt = SEARCH;
         end else begin
            case (state)
               SEARCH: begin
                  if (vedge) begin
                     state_nxt = VERIFY;
                     good_nxt  = 4'd0;
                  end
               end
               VERIFY: begin
                  if (vedge) begin
                     if (frame_good) begin
                        good_nxt = good + 4'd1;
                        if ((good + 4'd1) == LOCK_N) state_nxt = LOCKED;
                     end else begin
                        good_nxt = 4'd0;
                     end
                  end
               end
               LOCKED: begin
                  if (line_bad || (vcnt > V_LINES) || (vedge && (vcnt != V_LINES)))
                     state_nxt = SEARCH;
               end
               default: state_nxt = SEARCH;
            endcase
         end
      end
   end

   // Pixel/line counters, measurements and the per-frame line error flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hs_prev     <= 1'b0;
         vs_prev     <= 1'b0;
         hcnt        <= 10'd0;
         vcnt        <= 10'd0;
         line_len    <= 10'd0;
         frame_lines <= 10'd0;
         line_err    <= 1'b0;
      end else if (pix_en) begin
         hs_prev <= hs_n;
         vs_prev <= vs_n;
         if (hedge) begin
            line_len <= line_meas[9:0];
            hcnt     <= 10'd0;
         end else if (!hcnt_sat) begin
            hcnt <= hcnt + 10'd1;
         end
         if (vedge) begin
            frame_lines <= vcnt;
            vcnt        <= hedge ? 10'd1 : 10'd0;
            line_err    <= line_bad;
         end else begin
            if (hedge && !vcnt_sat) vcnt <= vcnt + 10'd1;
            if (line_bad) line_err <= 1'b1;
         end
      end
   end

   // Registered sync/RGB outputs; RGB passes only if the state was LOCKED before this sample.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hsync_out <= SYNC_IDLE;
         vsync_out <= SYNC_IDLE;
         csync_out <= SYNC_IDLE;
         rgb_out   <= 3'b000;
      end else if (pix_en) begin
         hsync_out <= hsync_in;
         vsync_out <= vsync_in;
         csync_out <= SYNC_HIGH ? (hs_n ^ vs_n) : ~(hs_n ^ vs_n);
         rgb_out   <= (state == LOCKED) ? rgb_in : 3'b000;
      end
   end

endmodule

// File: tb/tb_video_sync_monitor.sv
// Bench for video_sync_monitor: active-high and active-low instances driven with mirrored sync stimulus.
// Latency: expectations per pixel sample are checked 1 time unit after the sampling clk edge.
// Backpressure: none; pix_en alternates, with one long pix_en-low hold mid-line.
module tb_video_sync_monitor;

   localparam int HT = 20;
   localparam int VT = 8;

   typedef struct {
      logic [2:0] rgb;
      logic       hs;
      logic       vs;
      int         lk;
   } pix_t;

   typedef struct {
      int lk;
      int ll;
      int fl;
   } fr_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pix_en = 1'b0;
   logic       hsync_in = 1'b0, vsync_in = 1'b0;
   logic       hsync_in_n = 1'b1, vsync_in_n = 1'b1;
   logic [2:0] rgb_in = 3'd0;

   logic       hs_o, vs_o, cs_o, lk_o;
   logic [2:0] rgb_o;
   logic [9:0] ll_o, fl_o;
   logic       hs_on, vs_on, cs_on, lk_on;
   logic [2:0] rgb_on;
   logic [9:0] ll_on, fl_on;

   int checks = 0;
   int errors = 0;
   pix_t pixq[$];
   fr_t  frq[$];

   always #5 clk = ~clk;

   video_sync_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(4), .SYNC_HIGH(1'b1)) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .rgb_in(rgb_in), .hsync_out(hs_o), .vsync_out(vs_o), .csync_out(cs_o), .rgb_out(rgb_o),
      .locked(lk_o), .line_len(ll_o), .frame_lines(fl_o));

   video_sync_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(4), .SYNC_HIGH(1'b0)) dut_n (
      .clk(clk), .reset(reset), .pix_en(pix_en), .hsync_in(hsync_in_n), .vsync_in(vsync_in_n),
      .rgb_in(rgb_in), .hsync_out(hs_on), .vsync_out(vs_on), .csync_out(cs_on), .rgb_out(rgb_on),
      .locked(lk_on), .line_len(ll_on), .frame_lines(fl_on));

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   // One pixel: drive for a pix_en-high clk, queue the expected response, then a pix_en-low clk.
   task automatic pix(input logic h, input logic v, input logic [2:0] r, input logic [2:0] er, input int elk);
      pix_t p;
      @(negedge clk);
      pix_en     = 1'b1;
      hsync_in   = h;
      vsync_in   = v;
      hsync_in_n = ~h;
      vsync_in_n = ~v;
      rgb_in     = r;
      p.rgb = er; p.hs = h; p.vs = v; p.lk = elk;
      pixq.push_back(p);
      @(negedge clk);
      pix_en = 1'b0;
   endtask

   task automatic idle(input int n, input logic [2:0] r, input int elk);
      for (int i = 0; i < n; i++) pix(1'b0, 1'b0, r, 3'd0, elk);
   endtask

   // A frame: hsync high for 3 pixels per line, vsync for the first 2 lines. lk_prev/lk: lock before/after
   // the opening vedge; ll/fl: measurements shown at that vedge (ll<0 = not checked). Line sl gets length slen
   // and a lock held before it is expected to drop at the following hedge.
   task automatic send_frame(input int nl, input int sl, input int slen, input int lk_prev, input int lk,
                             input int ll, input int fl, input int hold_line);
      fr_t f;
      int cur;
      int len;
      logic [2:0] r, er;
      f.lk = lk; f.ll = ll; f.fl = fl;
      frq.push_back(f);
      cur = lk_prev;
      for (int l = 0; l < nl; l++) begin
         len = (l == sl) ? slen : HT;
         for (int p = 0; p < len; p++) begin
            r  = 3'(l + p + 1);
            er = (cur == 1) ? r : 3'd0;
            if (l == 0 && p == 0) cur = lk;
            if (sl >= 0 && l == sl + 1 && p == 0) cur = 0;
            pix(p < 3, l < 2, r, er, cur);
            if (l == hold_line && p == 10) begin
               repeat (100) @(negedge clk);
               chk("hold_locked", int'(lk_o), 1);
               chk("hold_locked_n", int'(lk_on), 1);
               chk("hold_line_len", int'(ll_o), HT);
               chk("hold_frame_lines", int'(fl_o), VT);
               chk("hold_rgb", int'(rgb_o), int'(er));
               chk("hold_hsync", int'(hs_o), 0);
               chk("hold_hsync_n", int'(hs_on), 1);
            end
         end
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_locked"}, int'(lk_o), 0);
      chk({tag, "_locked_n"}, int'(lk_on), 0);
      chk({tag, "_rgb"}, int'(rgb_o), 0);
      chk({tag, "_line_len"}, int'(ll_o), 0);
      chk({tag, "_frame_lines"}, int'(fl_o), 0);
      chk({tag, "_syncs"}, int'({hs_o, vs_o, cs_o}), 0);
      chk({tag, "_syncs_n"}, int'({hs_on, vs_on, cs_on}), 7);
   endtask

   // Monitor: after every pix_en sample pop the pixel expectation; on a vsync_out rise pop the frame expectation.
   initial begin : monitor
      pix_t pr;
      fr_t  fr;
      logic prev_v;
      prev_v = 1'b0;
      forever begin
         @(posedge clk);
         if (pix_en && reset) begin
            #1;
            if (pixq.size() == 0) begin
               chk("pix_queue_underflow", 1, 0);
            end else begin
               pr = pixq.pop_front();
               chk("rgb_out", int'(rgb_o), int'(pr.rgb));
               chk("rgb_out_n", int'(rgb_on), int'(pr.rgb));
               chk("sync_out", int'({hs_o, vs_o, cs_o}), int'({pr.hs, pr.vs, pr.hs ^ pr.vs}));
               chk("sync_out_n", int'({hs_on, vs_on, cs_on}), int'({~pr.hs, ~pr.vs, ~(pr.hs ^ pr.vs)}));
               if (pr.lk >= 0) begin
                  chk("locked_px", int'(lk_o), pr.lk);
                  chk("locked_px_n", int'(lk_on), pr.lk);
               end
            end
            if (vs_o && !prev_v) begin
               if (frq.size() == 0) begin
                  chk("frame_queue_underflow", 1, 0);
               end else begin
                  fr = frq.pop_front();
                  chk("frame_locked", int'(lk_o), fr.lk);
                  chk("frame_locked_n", int'(lk_on), fr.lk);
                  chk("frame_lines", int'(fl_o), fr.fl);
                  chk("frame_lines_n", int'(fl_on), fr.fl);
                  if (fr.ll >= 0) begin
                     chk("line_len", int'(ll_o), fr.ll);
                     chk("line_len_n", int'(ll_on), fr.ll);
                  end
               end
            end
            prev_v = vs_o;
         end
      end
   end

   initial begin : stimulus
      repeat (3) @(negedge clk);
      check_reset("reset_init");
      reset = 1'b1;
      // Pre-roll so the hedge at the first vedge measures exactly one nominal line.
      idle(HT - 1, 3'd5, 0);
      // Arm, four good frames, lock, one locked frame.
      send_frame(VT, -1, 0, 0, 0, HT, 0, -1);
      for (int i = 0; i < 3; i++) send_frame(VT, -1, 0, 0, 0, HT, VT, -1);
      send_frame(VT, -1, 0, 0, 1, HT, VT, -1);
      send_frame(VT, -1, 0, 1, 1, HT, VT, -1);
      // Short line while locked: drop at its closing hedge, re-lock five vedges later.
      send_frame(VT, 3, HT - 1, 1, 1, HT, VT, -1);
      for (int i = 0; i < 4; i++) send_frame(VT, -1, 0, 0, 0, HT, VT, -1);
      send_frame(VT, -1, 0, 0, 1, HT, VT, -1);
      // pix_en held low 100 clks mid-line.
      send_frame(VT, -1, 0, 1, 1, HT, VT, 3);
      send_frame(VT, -1, 0, 1, 1, HT, VT, -1);
      // hsync lost while locked: hcnt saturates at 1023.
      idle(900, 3'd0, -1);
      chk("sat_still_locked", int'(lk_o), 1);
      idle(200, 3'd0, -1);
      chk("sat_lost_lock", int'(lk_o), 0);
      chk("sat_lost_lock_n", int'(lk_on), 0);
      chk("sat_line_len_kept", int'(ll_o), HT);
      // First vedge is still saturated (no arm, bad line carried in), next one arms.
      send_frame(VT, -1, 0, 0, 0, -1, VT, -1);
      for (int i = 0; i < 3; i++) send_frame(VT, -1, 0, 0, 0, HT, VT, -1);
      // Three good frames counted; a short frame resets the count.
      send_frame(VT - 1, -1, 0, 0, 0, HT, VT, -1);
      send_frame(VT, -1, 0, 0, 0, HT, VT - 1, -1);
      for (int i = 0; i < 2; i++) send_frame(VT, -1, 0, 0, 0, HT, VT, -1);
      send_frame(VT, -1, 0, 0, 0, HT, VT, -1);
      send_frame(VT, -1, 0, 0, 1, HT, VT, -1);
      // Reset mid-frame while locked.
      send_frame(3, -1, 0, 1, 1, HT, VT, -1);
      chk("pre_reset_locked", int'(lk_o), 1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_reset("reset_mid");
      reset = 1'b1;
      chk("pix_queue_drained", pixq.size(), 0);
      chk("frame_queue_drained", frq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
